// File: rtl/kernel_a_pkg.sv
// Shared constants and helpers for the kernel_A input join stage.
package kernel_a_pkg;

    localparam int KA_STREAMW = 32;
    localparam int KA_DEPTH   = 4;
    localparam int KA_PTR_W   = $clog2(KA_DEPTH);
    localparam int KA_OCC_W   = KA_PTR_W + 1;

    // HOLD: first cycle after reset release; DONE only reachable with the item counter built in.
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } join_state_e;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int occ_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/kernel_a_input_join_if.sv
// Operand-in / joined-beat-out handshake bundle for kernel_a_input_join.
interface kernel_a_input_join_if #(
    parameter int STREAMW = 32
) ();
    logic [STREAMW-1:0] in0_data;
    logic               in0_valid;
    logic               in0_ready;
    logic [STREAMW-1:0] in1_data;
    logic               in1_valid;
    logic               in1_ready;
    logic [STREAMW-1:0] ka_vin0_s0;
    logic [STREAMW-1:0] ka_vin1_s0;
    logic               ovalid;
    logic               oready;

    // master: upstream readers plus kernel; slave: the join stage itself
    modport master (
        output in0_data, in0_valid, in1_data, in1_valid, oready,
        input  in0_ready, in1_ready, ka_vin0_s0, ka_vin1_s0, ovalid
    );

    modport slave (
        input  in0_data, in0_valid, in1_data, in1_valid, oready,
        output in0_ready, in1_ready, ka_vin0_s0, ka_vin1_s0, ovalid
    );
endinterface

// File: rtl/kernel_a_join_fifo.sv
// Single-stream first-word-fall-through FIFO; storage is not reset, only pointers/occupancy.
module kernel_a_join_fifo
    import kernel_a_pkg::*;
#(
    parameter int W     = KA_STREAMW,
    parameter int DEPTH = KA_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = ptr_w(DEPTH);
    localparam int OW = occ_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [OW-1:0] occ_q, occ_d;

    assign full_o  = (occ_q == OW'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign rdata_o = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (push_i) wr_d = wr_q + PW'(1);
        if (pop_i)  rd_d = rd_q + PW'(1);
        unique case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/kernel_a_input_join.sv
// Joins two valid/ready operand streams into one lock-step beat for kernel_A.
// Optional item counter / sticky done built in when KA_JOIN_COUNT_EN is defined.
module kernel_a_input_join
    import kernel_a_pkg::*;
#(
    parameter int STREAMW = KA_STREAMW,
    parameter int DEPTH   = KA_DEPTH,
    parameter int NITEMS  = 1024,
    parameter int CNTW    = 32
) (
    input  logic clk,
    input  logic rst,
`ifdef KA_JOIN_COUNT_EN
    output logic [CNTW-1:0] item_count,
    output logic            done,
`endif
    kernel_a_input_join_if.slave bus
);
    join_state_e        state_q, state_d;
    logic               full0, empty0, full1, empty1;
    logic               push0, push1, pop;
    logic               accept;
    logic [STREAMW-1:0] rdata0, rdata1;

    // Configuration sanity: an empty block elaborates only for illegal sizes.
    if (CNTW < $clog2(NITEMS + 1) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    end

    assign accept        = (state_q == ST_RUN);
    assign bus.in0_ready = accept & ~full0;
    assign bus.in1_ready = accept & ~full1;
    assign push0         = bus.in0_valid & bus.in0_ready;
    assign push1         = bus.in1_valid & bus.in1_ready;
    assign bus.ovalid    = accept & ~empty0 & ~empty1;
    assign pop           = bus.ovalid & bus.oready;
    assign bus.ka_vin0_s0 = rdata0;
    assign bus.ka_vin1_s0 = rdata1;

    kernel_a_join_fifo #(.W(STREAMW), .DEPTH(DEPTH)) u_fifo0 (
        .clk    (clk),
        .rst_n  (rst),
        .push_i (push0),
        .pop_i  (pop),
        .wdata_i(bus.in0_data),
        .rdata_o(rdata0),
        .full_o (full0),
        .empty_o(empty0)
    );

    kernel_a_join_fifo #(.W(STREAMW), .DEPTH(DEPTH)) u_fifo1 (
        .clk    (clk),
        .rst_n  (rst),
        .push_i (push1),
        .pop_i  (pop),
        .wdata_i(bus.in1_data),
        .rdata_o(rdata1),
        .full_o (full1),
        .empty_o(empty1)
    );

`ifdef KA_JOIN_COUNT_EN
    logic [CNTW-1:0] count_q, count_d;
    logic            last_beat;

    assign last_beat  = pop & (count_q == CNTW'(NITEMS - 1));
    assign item_count = count_q;
    assign done       = (state_q == ST_DONE);
    assign count_d    = pop ? count_q + CNTW'(1) : count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end
`else
    logic last_beat;
    assign last_beat = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HOLD: state_d = ST_RUN;
            ST_RUN:  if (last_beat) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_HOLD;
        else      state_q <= state_d;
    end

endmodule

// File: tb/tb_kernel_a_input_join.sv
// Directed and scoreboarded bench for kernel_a_input_join (DEPTH=4; NITEMS=8 when KA_JOIN_COUNT_EN).
module tb_kernel_a_input_join;
    localparam int STREAMW = 32;
    localparam int DEPTH   = 4;
    localparam int NITEMS  = 8;
    localparam int CNTW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    kernel_a_input_join_if #(.STREAMW(STREAMW)) bus ();

`ifdef KA_JOIN_COUNT_EN
    logic [CNTW-1:0] item_count;
    logic            done;
`endif

    kernel_a_input_join #(
        .STREAMW(STREAMW), .DEPTH(DEPTH), .NITEMS(NITEMS), .CNTW(CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef KA_JOIN_COUNT_EN
        .item_count(item_count),
        .done      (done),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        ordy;
        logic        er0;
        logic        er1;
        logic        eov;
        logic [31:0] ed0;
        logic [31:0] ed1;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [31:0] d0, input logic v1,
                         input logic [31:0] d1, input logic ordy);
        bus.in0_valid = v0;
        bus.in0_data  = d0;
        bus.in1_valid = v1;
        bus.in1_data  = d1;
        bus.oready    = ordy;
    endtask

    function automatic vec_t mk(input logic v0, input int d0, input logic v1, input int d1,
                                input logic r0, input logic r1, input logic ov,
                                input int e0, input int e1);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = 1'b1;
        v.er0 = r0; v.er1 = r1; v.eov = ov; v.ed0 = e0; v.ed1 = e1;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        int   hs;
        int   k;
        int   beats;
        int   sent0;
        int   sent1;
        int   cyc;
        logic acc0;
        logic acc1;

        // in0 runs ahead by DEPTH, then in1 catches up; rows: inputs | readies, ovalid, data
        tbl[0]  = mk(1, 10, 0,  0, 1, 1, 0,  0,  0);
        tbl[1]  = mk(1, 11, 0,  0, 1, 1, 0,  0,  0);
        tbl[2]  = mk(1, 12, 0,  0, 1, 1, 0,  0,  0);
        tbl[3]  = mk(1, 13, 0,  0, 1, 1, 0,  0,  0);
        tbl[4]  = mk(1, 14, 0,  0, 0, 1, 0,  0,  0);
        tbl[5]  = mk(1, 14, 0,  0, 0, 1, 0,  0,  0);
        tbl[6]  = mk(1, 14, 1, 20, 0, 1, 0,  0,  0);
        tbl[7]  = mk(1, 14, 1, 21, 0, 1, 1, 10, 20);
        tbl[8]  = mk(1, 14, 1, 22, 1, 1, 1, 11, 21);
        tbl[9]  = mk(1, 15, 1, 23, 1, 1, 1, 12, 22);
        tbl[10] = mk(0,  0, 0,  0, 1, 1, 1, 13, 23);
        tbl[11] = mk(0,  0, 1, 24, 1, 1, 0,  0,  0);
        tbl[12] = mk(0,  0, 0,  0, 1, 1, 1, 14, 24);
        tbl[13] = mk(0,  0, 1, 25, 1, 1, 0,  0,  0);
        tbl[14] = mk(0,  0, 0,  0, 1, 1, 1, 15, 25);
        tbl[15] = mk(0,  0, 0,  0, 1, 1, 0,  0,  0);

        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in0_ready", bus.in0_ready, 0);
        chk("reset_in1_ready", bus.in1_ready, 0);
        chk("reset_ovalid", bus.ovalid, 0);
`ifdef KA_JOIN_COUNT_EN
        chk("reset_item_count", item_count, 0);
        chk("reset_done", done, 0);

        tick();
        rst = 1'b1;
        k = 0;
        drive(1, 0, 1, 1000, 1);
        hs = 0;
        cyc = 0;
        while (hs < NITEMS && cyc < 40) begin
            @(negedge clk);
            if (bus.ovalid && bus.oready) begin
                hs++;
                if (hs == NITEMS) begin
                    chk("count_before_last", item_count, NITEMS - 1);
                    chk("done_before_last", done, 0);
                end
            end
            if (bus.in0_ready) k++;
            tick();
            bus.in0_data = k;
            bus.in1_data = 1000 + k;
            cyc++;
        end
        chk("count_handshakes", hs, NITEMS);
        @(negedge clk);
        chk("done_set", done, 1);
        chk("item_count_final", item_count, NITEMS);
        chk("ovalid_after_done", bus.ovalid, 0);
        chk("in0_ready_after_done", bus.in0_ready, 0);
        chk("in1_ready_after_done", bus.in1_ready, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("done_sticky", done, 1);
        chk("item_count_frozen", item_count, NITEMS);
`else
        // Streaming from reset release
        tick();
        rst = 1'b1;
        drive(1, 0, 1, 1000, 1);
        @(negedge clk);
        chk("ready_low_after_release", {bus.in0_ready, bus.in1_ready}, 0);
        tick();
        @(negedge clk);
        chk("ready_high_run", {bus.in0_ready, bus.in1_ready}, 2'b11);
        chk("ovalid_before_first_push", bus.ovalid, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            bus.in0_data = i;
            bus.in1_data = 1000 + i;
            @(negedge clk);
            chk("stream_ovalid", bus.ovalid, 1);
            chk("stream_vin0", bus.ka_vin0_s0, i - 1);
            chk("stream_vin1", bus.ka_vin1_s0, 1000 + i - 1);
        end
        tick();
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("stream_last_vin0", bus.ka_vin0_s0, 8);
        chk("stream_last_ovalid", bus.ovalid, 1);
        tick();
        @(negedge clk);
        chk("stream_drained", bus.ovalid, 0);

        // Skew table
        for (int r = 0; r < 16; r++) begin
            tick();
            drive(tbl[r].v0, tbl[r].d0, tbl[r].v1, tbl[r].d1, tbl[r].ordy);
            @(negedge clk);
            chk($sformatf("skew%0d_in0_ready", r), bus.in0_ready, tbl[r].er0);
            chk($sformatf("skew%0d_in1_ready", r), bus.in1_ready, tbl[r].er1);
            chk($sformatf("skew%0d_ovalid", r), bus.ovalid, tbl[r].eov);
            if (tbl[r].eov) begin
                chk($sformatf("skew%0d_vin0", r), bus.ka_vin0_s0, tbl[r].ed0);
                chk($sformatf("skew%0d_vin1", r), bus.ka_vin1_s0, tbl[r].ed1);
            end
        end

        // Both FIFOs full, kernel stalled
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            drive(1, 100 + i, 1, 200 + i, 0);
        end
        tick();
        drive(1, 100 + DEPTH, 1, 200 + DEPTH, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_ovalid", bus.ovalid, 1);
            chk("stall_vin0", bus.ka_vin0_s0, 100);
            chk("stall_vin1", bus.ka_vin1_s0, 200);
            chk("stall_readies", {bus.in0_ready, bus.in1_ready}, 0);
            tick();
        end
        for (int j = 0; j <= DEPTH; j++) begin
            if (j == 0) bus.oready = 1'b1;
            if (j == 2) begin
                bus.in0_valid = 1'b0;
                bus.in1_valid = 1'b0;
            end
            @(negedge clk);
            if (j == 0) chk("unstall_in0_ready_full", bus.in0_ready, 0);
            chk("unstall_ovalid", bus.ovalid, 1);
            chk("unstall_vin0", bus.ka_vin0_s0, 100 + j);
            chk("unstall_vin1", bus.ka_vin1_s0, 200 + j);
            tick();
        end
        @(negedge clk);
        chk("unstall_drained", bus.ovalid, 0);

        // Random valid/oready with in-order scoreboard
        beats = 0; sent0 = 0; sent1 = 0; cyc = 0; acc0 = 0; acc1 = 0;
        drive(0, 0, 0, 0, 0);
        while (beats < 500 && cyc < 8000) begin
            tick();
            if (!bus.in0_valid || acc0) begin
                bus.in0_valid = ($urandom_range(0, 3) != 0);
                bus.in0_data  = 3000 + sent0;
            end
            if (!bus.in1_valid || acc1) begin
                bus.in1_valid = ($urandom_range(0, 2) != 0);
                bus.in1_data  = 7000 + sent1;
            end
            bus.oready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc0 = bus.in0_valid && bus.in0_ready;
            acc1 = bus.in1_valid && bus.in1_ready;
            if (acc0) sent0++;
            if (acc1) sent1++;
            if (bus.ovalid && bus.oready) begin
                chk("rand_vin0", bus.ka_vin0_s0, 3000 + beats);
                chk("rand_vin1", bus.ka_vin1_s0, 7000 + beats);
                beats++;
            end
            cyc++;
        end
        chk("rand_beats", beats, 500);

        // Reset mid-run with entries buffered
        tick();
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 50 + i, 1, 60 + i, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("prereset_ovalid", bus.ovalid, 1);
        chk("prereset_vin0", bus.ka_vin0_s0, 50);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_ovalid", bus.ovalid, 0);
        chk("async_reset_readies", {bus.in0_ready, bus.in1_ready}, 0);
        tick();
        rst = 1'b1;
        drive(1, 70, 1, 80, 1);
        @(negedge clk);
        chk("rerelease_ready_low", {bus.in0_ready, bus.in1_ready}, 0);
        chk("rerelease_ovalid", bus.ovalid, 0);
        tick();
        @(negedge clk);
        chk("rerelease_ready_high", {bus.in0_ready, bus.in1_ready}, 2'b11);
        chk("rerelease_no_old_beat", bus.ovalid, 0);
        tick();
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("new_beat_ovalid", bus.ovalid, 1);
        chk("new_beat_vin0", bus.ka_vin0_s0, 70);
        chk("new_beat_vin1", bus.ka_vin1_s0, 80);
        tick();
        @(negedge clk);
        chk("old_entries_gone", bus.ovalid, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kernel_a_input_join.md
# kernel_a_input_join

Upstream input stage for the kernel_A top-level: it joins two independent valid/ready operand streams (vin0, vin1) into the single lock-step handshake the kernel consumes. Each operand stream gets its own small elastic FIFO. A joined beat is released only when both FIFOs hold data, so one-sided stalls and skew between the two memory readers never misalign operands. An optional item counter raises a sticky completion flag after a fixed number of joined beats.

## Interface
- STREAMW, 32, width of each operand word
- DEPTH, 4, entries per operand FIFO; power of two, ≥2
- NITEMS, 1024, joined beats per run (counter feature only)
- CNTW, 32, item counter width; must satisfy 2^CNTW > NITEMS
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- in0_data  in  STREAMW  operand 0 word from upstream reader
- in0_valid  in  1  operand 0 word valid
- in0_ready  out  1  operand 0 FIFO can accept
- in1_data  in  STREAMW  operand 1 word
- in1_valid  in  1  operand 1 word valid
- in1_ready  out  1  operand 1 FIFO can accept
- ka_vin0_s0  out  STREAMW  joined operand 0 to kernel
- ka_vin1_s0  out  STREAMW  joined operand 1 to kernel
- ovalid  out  1  joined beat valid (drives kernel ivalid)
- oready  in  1  kernel iready
- item_count  out  CNTW  joined beats delivered (KA_JOIN_COUNT_EN only)
- done  out  1  sticky run-complete (KA_JOIN_COUNT_EN only)

## Operation
- run flag: cleared by reset, set on first clk edge after rst rises; inN_ready = run & !fullN.
- Push on inN_valid & inN_ready; word written at wr_ptr; wr_ptr += 1 mod DEPTH.
- First-word fall-through: ka_vinN_s0 = mem[rd_ptr] of FIFO N; undefined-but-stable while empty.
- ovalid = !empty0 & !empty1 (& !done when counter compiled in).
- Pop both FIFOs together on ovalid & oready; never pop one alone.
- Occupancy counter per FIFO, width clog2(DEPTH)+1: +1 on push only, −1 on pop only, unchanged on push+pop.
- Full: ready low; no push that cycle even if a pop occurs (ready depends on occupancy only, no combinational path from oready to inN_ready).
- Empty FIFO with push: word visible at output the next cycle; not bypassed.
- ovalid, once high, stays high and data stays stable until oready (AXI-style hold); inputs must obey the same rule.

## Timing
- Reset values: in0_ready=0, in1_ready=0, ovalid=0, item_count=0, done=0; pointers/occupancy 0. ka_vinN_s0 don't-care.
- Reset asserted mid-run: all FIFO contents discarded immediately (async); no beat emitted until both inputs push anew.
- Latency input push → ovalid: 1 cycle (when other operand already present).
- Sustained throughput: 1 joined beat/cycle when both inputs stream and oready=1.
- Skew tolerance: up to DEPTH beats of one operand ahead of the other before that side back-pressures.

## Configuration
- KA_JOIN_COUNT_EN defined: item_count increments on each output handshake; when it reaches NITEMS, done sets next edge and stays set until reset; while done, ovalid=0 and inN_ready=0 (further inputs held off), item_count frozen at NITEMS.
- Undefined: no counter or done logic; item_count and done ports absent; ovalid/ready depend only on FIFO state.

## Structure
- Shared package kernel_a_pkg: STREAMW default, DEPTH default, pointer width constant clog2(DEPTH), occupancy width constant.
- One sub-module: kernel_a_join_fifo (single-stream FWFT FIFO with push/pop, full, empty), instantiated twice; join, run flag, and counter logic live in the top.

## Test plan
- Reset release, both valid every cycle, data in0=k, in1=1000+k, oready=1 → readies 0 for 1 cycle after release, then first ovalid 1 cycle after first push, then one beat/cycle, pairs (k, 1000+k) in order.
- in0 streams 6 words while in1 idle, DEPTH=4 → in0_ready drops after 4 pushes, ovalid=0; then in1 sends 4 words → 4 beats pair correctly, in0 resumes.
- oready held 0 for 10 cycles with both full → ovalid=1, outputs stable, both readies 0, no push accepted.
- Random valid/oready toggling, 500 beats → scoreboard matches in order, no loss or duplication.
- KA_JOIN_COUNT_EN, NITEMS=8 → done rises the cycle after the 8th handshake, item_count=8, ovalid and readies 0 thereafter.
- rst pulsed low with 3 entries buffered → outputs reset within the same cycle; after release, first beat is the new data, old entries never appear.
